// File: rtl/jpeg_bit_packer.sv
// Packs right-aligned variable-length Huffman codes MSB-first into an entropy-coded
// byte stream, with optional 0x00 stuffing after 0xFF and 1-padding on flush.
module jpeg_bit_packer #(
   parameter bit STUFF_EN = 1'b1,
   parameter int MAX_LEN  = 16
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        code_valid,
   output logic        code_ready,
   input  logic [15:0] code_bits,
   input  logic [7:0]  code_len,
   input  logic        flush,
   output logic        byte_valid,
   input  logic        byte_ready,
   output logic [7:0]  byte_data,
   output logic        flush_done,
   output logic        busy
);

   // state    | meaning
   // ST_RUN   | accepting codes, emitting whole bytes
   // ST_FLUSH | no codes accepted; drain, pad last partial byte, then pulse flush_done
   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   state_t      state_q, state_d;
   logic [23:0] acc_q, acc_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        stuff_pending_q, stuff_pending_d;
   logic [7:0]  byte_data_q, byte_data_d;
   logic        byte_valid_q, byte_valid_d;
   logic        flush_done_q, flush_done_d;

   logic [4:0]  len_eff;
   logic [15:0] code_mask;
   logic [5:0]  shift_amt;
   logic [23:0] code_ins;
   logic [7:0]  pad_byte;
   logic        slot_free;
   logic        accept;

   assign code_ready = (state_q == ST_RUN) && (cnt_q < 5'd8);
   assign slot_free  = !byte_valid_q || byte_ready;
   assign accept     = code_valid && code_ready;
   assign byte_valid = byte_valid_q;
   assign byte_data  = byte_data_q;
   assign flush_done = flush_done_q;
   assign busy       = (cnt_q != 5'd0) || byte_valid_q || stuff_pending_q || (state_q == ST_FLUSH);

   always_comb begin
      len_eff = (code_len > 8'(MAX_LEN)) ? 5'(MAX_LEN) : code_len[4:0];
      code_mask = 16'((17'd1 << len_eff) - 17'd1);
      // Shift amount only meaningful while accepting (cnt<8, len<=16 keeps it >=1)
      shift_amt = 6'd24 - {1'b0, cnt_q} - {1'b0, len_eff};
      code_ins  = {8'h00, code_bits & code_mask} << shift_amt;
      pad_byte  = acc_q[23:16] | (8'hFF >> cnt_q);

      state_d         = state_q;
      acc_d           = acc_q;
      cnt_d           = cnt_q;
      stuff_pending_d = stuff_pending_q;
      byte_data_d     = byte_data_q;
      byte_valid_d    = byte_valid_q;
      flush_done_d    = 1'b0;

      if (slot_free) begin
         if (stuff_pending_q) begin
            byte_data_d     = 8'h00;
            byte_valid_d    = 1'b1;
            stuff_pending_d = 1'b0;
         end else if (cnt_q >= 5'd8) begin
            byte_data_d     = acc_q[23:16];
            byte_valid_d    = 1'b1;
            acc_d           = {acc_q[15:0], 8'h00};
            cnt_d           = cnt_q - 5'd8;
            stuff_pending_d = STUFF_EN && (acc_q[23:16] == 8'hFF);
         end else if ((state_q == ST_FLUSH) && (cnt_q != 5'd0)) begin
            byte_data_d     = pad_byte;
            byte_valid_d    = 1'b1;
            acc_d           = 24'h000000;
            cnt_d           = 5'd0;
            stuff_pending_d = STUFF_EN && (pad_byte == 8'hFF);
         end else begin
            byte_valid_d    = 1'b0;
         end
      end

      // Acceptance never coincides with extraction or padding, so acc_d == acc_q here
      if (accept) begin
         acc_d = acc_d | code_ins;
         cnt_d = cnt_d + len_eff;
      end

      case (state_q)
         ST_RUN: begin
            if (flush) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (slot_free && (cnt_q == 5'd0) && !stuff_pending_q) begin
               state_d      = ST_RUN;
               flush_done_d = 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= ST_RUN;
         acc_q           <= 24'h000000;
         cnt_q           <= 5'd0;
         stuff_pending_q <= 1'b0;
         byte_data_q     <= 8'h00;
         byte_valid_q    <= 1'b0;
         flush_done_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         acc_q           <= acc_d;
         cnt_q           <= cnt_d;
         stuff_pending_q <= stuff_pending_d;
         byte_data_q     <= byte_data_d;
         byte_valid_q    <= byte_valid_d;
         flush_done_q    <= flush_done_d;
      end
   end

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Directed bench for jpeg_bit_packer: a stuffing instance and a raw (no stuffing)
// instance share stimulus; emitted bytes are scored against per-instance queues.
module tb_jpeg_bit_packer;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        code_valid = 1'b0;
   logic [15:0] code_bits = 16'h0;
   logic [7:0]  code_len = 8'h0;
   logic        flush = 1'b0;
   logic        byte_ready = 1'b1;

   logic        code_ready, byte_valid, flush_done, busy;
   logic [7:0]  byte_data;
   logic        raw_code_ready, raw_byte_valid, raw_flush_done, raw_busy;
   logic [7:0]  raw_byte_data;

   int n_cmp = 0;
   int n_bad = 0;
   int fd_cnt = 0;
   int fd0;
   logic [7:0] exp_q[$];
   logic [7:0] raw_q[$];
   logic       stall_prev = 1'b0;
   logic [7:0] data_prev = 8'h00;

   jpeg_bit_packer #(.STUFF_EN(1'b1), .MAX_LEN(16)) u_dut (
      .clock(clock), .reset_n(reset_n), .code_valid(code_valid), .code_ready(code_ready),
      .code_bits(code_bits), .code_len(code_len), .flush(flush), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .byte_data(byte_data), .flush_done(flush_done), .busy(busy));

   jpeg_bit_packer #(.STUFF_EN(1'b0), .MAX_LEN(16)) u_raw (
      .clock(clock), .reset_n(reset_n), .code_valid(code_valid), .code_ready(raw_code_ready),
      .code_bits(code_bits), .code_len(code_len), .flush(flush), .byte_valid(raw_byte_valid),
      .byte_ready(byte_ready), .byte_data(raw_byte_data), .flush_done(raw_flush_done),
      .busy(raw_busy));

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [15:0] bits, input logic [7:0] len);
      int k = 0;
      code_bits  = bits;
      code_len   = len;
      code_valid = 1'b1;
      while (!(code_ready && raw_code_ready) && k < 50) begin
         tick();
         k++;
      end
      check("send_ready_timeout", k, k < 50 ? k : 0);
      tick();
      code_valid = 1'b0;
   endtask

   task automatic pulse_flush(input int n);
      flush = 1'b1;
      repeat (n) tick();
      flush = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((busy || raw_busy) && k < 100) begin
         tick();
         k++;
      end
      check("idle_timeout", 32'(k < 100), 32'd1);
      repeat (2) tick();
   endtask

   // Scoreboard pop on every handshake, hold-rule check while stalled
   always @(negedge clock) begin
      if (!reset_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", byte_valid, 1'b1);
            check("hold_data", byte_data, data_prev);
         end
         stall_prev = byte_valid && !byte_ready;
         data_prev  = byte_data;
         if (byte_valid && byte_ready) begin
            n_cmp++;
            assert (exp_q.size() > 0) else begin
               n_bad++;
               $error("FAIL byte_extra: observed %0h expected none", byte_data);
            end
            if (exp_q.size() > 0) check("byte", byte_data, exp_q.pop_front());
         end
         if (raw_byte_valid && byte_ready) begin
            n_cmp++;
            assert (raw_q.size() > 0) else begin
               n_bad++;
               $error("FAIL raw_byte_extra: observed %0h expected none", raw_byte_data);
            end
            if (raw_q.size() > 0) check("raw_byte", raw_byte_data, raw_q.pop_front());
         end
         if (flush_done) begin
            fd_cnt++;
            check("flush_done_after_bytes", exp_q.size(), 0);
         end
      end
   end

   initial begin
      // reset values
      repeat (2) tick();
      check("rst_byte_valid", byte_valid, 1'b0);
      check("rst_byte_data", byte_data, 8'h00);
      check("rst_flush_done", flush_done, 1'b0);
      check("rst_busy", busy, 1'b0);
      reset_n = 1'b1;
      tick();
      check("rst_code_ready", code_ready, 1'b1);

      // 00 + 1010, flush -> 0x2B
      fd0 = fd_cnt;
      exp_q.push_back(8'h2B); raw_q.push_back(8'h2B);
      send(16'h0000, 8'd2);
      send(16'h000A, 8'd4);
      pulse_flush(1);
      wait_idle();
      check("t1_flush_done_cnt", fd_cnt - fd0, 1);
      check("t1_busy", busy, 1'b0);

      // 0xFF len 8: stuffed FF 00, raw FF; latency one cycle after accept
      exp_q.push_back(8'hFF); exp_q.push_back(8'h00); raw_q.push_back(8'hFF);
      send(16'h00FF, 8'd8);
      check("t2_valid_accept_edge", byte_valid, 1'b0);
      tick();
      check("t2_valid_next_edge", byte_valid, 1'b1);
      check("t2_data_next_edge", byte_data, 8'hFF);
      wait_idle();

      // 0xABCD len 16 with downstream stalled
      byte_ready = 1'b0;
      exp_q.push_back(8'hAB); exp_q.push_back(8'hCD);
      raw_q.push_back(8'hAB); raw_q.push_back(8'hCD);
      send(16'hABCD, 8'd16);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("t3_stall_valid", byte_valid, 1'b1);
         check("t3_stall_data", byte_data, 8'hAB);
         check("t3_stall_code_ready", code_ready, 1'b0);
         tick();
      end
      byte_ready = 1'b1;
      wait_idle();
      check("t3_code_ready_after", code_ready, 1'b1);

      // clamp len>16, len 0 no-op, bits above len ignored
      exp_q.push_back(8'h5A); exp_q.push_back(8'h5A);
      raw_q.push_back(8'h5A); raw_q.push_back(8'h5A);
      send(16'h5A5A, 8'd40);
      wait_idle();
      exp_q.push_back(8'h7F); raw_q.push_back(8'h7F);
      send(16'hFFF3, 8'd3);
      send(16'hFFFF, 8'd0);
      send(16'hFF1F, 8'd5);
      wait_idle();

      // 11111 + flush -> padded FF then stuffing 00
      fd0 = fd_cnt;
      exp_q.push_back(8'hFF); exp_q.push_back(8'h00); raw_q.push_back(8'hFF);
      send(16'h001F, 8'd5);
      pulse_flush(1);
      wait_idle();
      check("t4_flush_done_cnt", fd_cnt - fd0, 1);

      // empty flush, second flush during FLUSH ignored
      fd0 = fd_cnt;
      pulse_flush(2);
      wait_idle();
      repeat (3) tick();
      check("t5_flush_done_cnt", fd_cnt - fd0, 1);
      check("t5_busy", busy, 1'b0);

      // reset mid-stream discards pending bits
      send(16'h0005, 8'd3);
      check("t6_busy_before_reset", busy, 1'b1);
      reset_n = 1'b0;
      #1;
      check("t6_busy_in_reset", busy, 1'b0);
      check("t6_valid_in_reset", byte_valid, 1'b0);
      tick();
      reset_n = 1'b1;
      tick();
      check("t6_data", byte_data, 8'h00);
      check("t6_flush_done", flush_done, 1'b0);
      check("t6_code_ready", code_ready, 1'b1);
      fd0 = fd_cnt;
      pulse_flush(1);
      wait_idle();
      repeat (3) tick();
      check("t6_flush_done_cnt", fd_cnt - fd0, 1);

      check("exp_q_drained", exp_q.size(), 0);
      check("raw_q_drained", raw_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
